// File: rtl/async_fifo.sv
// async_fifo: single-clock first-word-fall-through FIFO with full/empty flags,
// occupancy count and optional sticky overflow/underflow error flags.
// Define ASYNC_FIFO_ERR_EN to implement the sticky error registers; without it
// the overflow/underflow ports are tied to 0.
// DEPTH must be a power of two and at least 2.
module async_fifo #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 8,
  localparam int AW        = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic                  full,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  empty,
  output logic [AW:0]           count,
  output logic                  overflow,
  output logic                  underflow
);

  // Storage is deliberately left out of reset; pointers alone define validity.
  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]           r_wr_ptr;
  logic [AW:0]           r_rd_ptr;

  logic w_full;
  logic w_empty;
  logic w_push;
  logic w_pop;

  // Flags derive only from registered pointers, never from wr_en/rd_en.
  assign w_empty = (r_wr_ptr == r_rd_ptr);
  assign w_full  = (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]) &&
                   (r_wr_ptr[AW] != r_rd_ptr[AW]);
  assign w_push  = wr_en && !w_full;
  assign w_pop   = rd_en && !w_empty;

  assign full    = w_full;
  assign empty   = w_empty;
  assign count   = r_wr_ptr - r_rd_ptr;
  assign rd_data = w_empty ? '0 : r_mem[r_rd_ptr[AW-1:0]];

  // Write accepted entries into the array at the current write index.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr[AW-1:0]] <= wr_data;
    end
  end

  // Advance the write pointer on every accepted push; wrap bit rolls over naturally.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_ptr <= '0;
    end else if (w_push) begin
      r_wr_ptr <= r_wr_ptr + 1'b1;
    end
  end

  // Advance the read pointer on every accepted pop.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rd_ptr <= '0;
    end else if (w_pop) begin
      r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

`ifdef ASYNC_FIFO_ERR_EN
  logic r_overflow;
  logic r_underflow;

  // Sticky error flags, cleared only by reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if (wr_en && w_full) begin
        r_overflow <= 1'b1;
      end
      if (rd_en && w_empty) begin
        r_underflow <= 1'b1;
      end
    end
  end

  assign overflow  = r_overflow;
  assign underflow = r_underflow;
`else
  assign overflow  = 1'b0;
  assign underflow = 1'b0;
`endif

endmodule

// File: tb/tb_async_fifo.sv
// Directed self-checking bench for async_fifo (DATA_WIDTH=16, DEPTH=8).
module tb_async_fifo;

  localparam int DW = 16;
  localparam int DEPTH = 8;
  localparam int AW = $clog2(DEPTH);
`ifdef ASYNC_FIFO_ERR_EN
  localparam logic ERR = 1'b1;
`else
  localparam logic ERR = 1'b0;
`endif

  logic          clk;
  logic          reset_n;
  logic          wr_en;
  logic [DW-1:0] wr_data;
  logic          full;
  logic          rd_en;
  logic [DW-1:0] rd_data;
  logic          empty;
  logic [AW:0]   count;
  logic          overflow;
  logic          underflow;

  int checks = 0;
  int failures = 0;
  logic [DW-1:0] q[$];
  logic [DW-1:0] head;

  async_fifo #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .wr_en    (wr_en),
    .wr_data  (wr_data),
    .full     (full),
    .rd_en    (rd_en),
    .rd_data  (rd_data),
    .empty    (empty),
    .count    (count),
    .overflow (overflow),
    .underflow(underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock edge and settle 1 time unit past it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset_n = 1'b0;
    wr_en   = 1'b0;
    rd_en   = 1'b0;
    wr_data = '0;
    tick();
    tick();
    reset_n = 1'b1;
    tick();

    // Idle after reset
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_full", 32'(full), 32'd0);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_rd_data", 32'(rd_data), 32'h0);
    chk("rst_overflow", 32'(overflow), 32'd0);
    chk("rst_underflow", 32'(underflow), 32'd0);

    // Fill with 0x11..0x88
    for (int i = 1; i <= 8; i++) begin
      wr_en   = 1'b1;
      wr_data = DW'(i * 16 + i);
      tick();
      if (i == 1) begin
        chk("first_push_empty", 32'(empty), 32'd0);
        chk("first_push_head", 32'(rd_data), 32'h11);
      end
    end
    wr_en = 1'b0;
    chk("fill_full", 32'(full), 32'd1);
    chk("fill_count", 32'(count), 32'd8);

    // Push while full is dropped
    wr_en   = 1'b1;
    wr_data = 16'hDEAD;
    tick();
    wr_en = 1'b0;
    chk("ovf_count", 32'(count), 32'd8);
    chk("ovf_head", 32'(rd_data), 32'h11);
    chk("ovf_full", 32'(full), 32'd1);
    chk("ovf_flag", 32'(overflow), 32'(ERR));

    // Drain in order
    for (int i = 1; i <= 8; i++) begin
      chk($sformatf("drain_%0d", i), 32'(rd_data), 32'(i * 16 + i));
      rd_en = 1'b1;
      tick();
    end
    rd_en = 1'b0;
    chk("drain_empty", 32'(empty), 32'd1);
    chk("drain_count", 32'(count), 32'd0);
    chk("drain_rd_data", 32'(rd_data), 32'h0);
    chk("drain_ovf_sticky", 32'(overflow), 32'(ERR));

    // Pop while empty alongside a push
    rd_en   = 1'b1;
    wr_en   = 1'b1;
    wr_data = 16'h005A;
    tick();
    rd_en = 1'b0;
    wr_en = 1'b0;
    chk("unf_flag", 32'(underflow), 32'(ERR));
    chk("unf_rd_data", 32'(rd_data), 32'h5A);
    chk("unf_count", 32'(count), 32'd1);

    // Build occupancy to 4
    q.push_back(16'h005A);
    for (int i = 1; i <= 3; i++) begin
      wr_en   = 1'b1;
      wr_data = DW'(16'h0100 + i);
      q.push_back(wr_data);
      tick();
    end
    wr_en = 1'b0;
    chk("steady_count_start", 32'(count), 32'd4);

    // 20 cycles of simultaneous push/pop across the pointer wrap
    for (int i = 0; i < 20; i++) begin
      head = q.pop_front();
      chk($sformatf("steady_data_%0d", i), 32'(rd_data), 32'(head));
      wr_en   = 1'b1;
      rd_en   = 1'b1;
      wr_data = DW'(16'h0200 + i);
      q.push_back(wr_data);
      tick();
      chk($sformatf("steady_count_%0d", i), 32'(count), 32'd4);
    end
    wr_en = 1'b0;
    rd_en = 1'b0;
    chk("steady_tail_head", 32'(rd_data), 32'h0210);

    // Occupancy 5, then asynchronous reset mid-cycle
    wr_en   = 1'b1;
    wr_data = 16'h0BEE;
    tick();
    wr_en = 1'b0;
    chk("pre_areset_count", 32'(count), 32'd5);
    #2;
    reset_n = 1'b0;
    #1;
    chk("areset_empty", 32'(empty), 32'd1);
    chk("areset_count", 32'(count), 32'd0);
    chk("areset_full", 32'(full), 32'd0);
    chk("areset_rd_data", 32'(rd_data), 32'h0);
    chk("areset_overflow", 32'(overflow), 32'd0);
    chk("areset_underflow", 32'(underflow), 32'd0);
    tick();
    reset_n = 1'b1;
    tick();
    chk("post_reset_empty", 32'(empty), 32'd1);
    chk("post_reset_count", 32'(count), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
